yl3_display_arbiter: RTL

- Shares the single 8-digit YL-3 serial display driver between NUM_REQ requesters, each supplying a 64-bit, 8-character ASCII message.
- Arbitrates round-robin and runs the driver's load/ready handshake.
- Enforces a minimum on-screen dwell time per message.
- Periodically re-sends the current message to repair display corruption.
- Sits between application logic (status, counters, debug) and the driver.

---
 rtl/yl3_pkg.sv | 22 ++
 rtl/yl3_display_arbiter_if.sv | 12 +
 rtl/yl3_rr_arbiter.sv | 32 +++
 rtl/yl3_display_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/yl3_pkg.sv
// Shared types and constants for the YL-3 display arbiter slice.
package yl3_pkg;

   localparam int unsigned YL3_MSG_W = 64;
   localparam logic [YL3_MSG_W-1:0] YL3_BLANK_MSG = 64'h2020_2020_2020_2020;

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StArb     = 3'd1;
   localparam logic [2:0] StWaitRdy = 3'd2;
   localparam logic [2:0] StLoad    = 3'd3;
   localparam logic [2:0] StBusy    = 3'd4;
   localparam logic [2:0] StDwell   = 3'd5;

   function automatic int unsigned yl3_idw(input int unsigned n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   function automatic logic [31:0] yl3_sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/yl3_display_arbiter_if.sv
// Load/ready link between the arbiter (master) and the YL-3 serial driver (slave).
interface yl3_display_arbiter_if;
   import yl3_pkg::*;

   logic [YL3_MSG_W-1:0] drv_data;
   logic                 drv_load;
   logic                 drv_ready;

   modport master (output drv_data, output drv_load, input drv_ready);
   modport slave  (input drv_data, input drv_load, output drv_ready);

endinterface

// File: rtl/yl3_rr_arbiter.sv
// Combinational round-robin picker; search begins one past ptr.
module yl3_rr_arbiter
   import yl3_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   localparam int unsigned IDW = yl3_idw(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDW-1:0]     idx,
   output logic               any_req
);

   logic [IDW-1:0] j;

   always_comb begin
      grant   = '0;
      idx     = '0;
      any_req = 1'b0;
      j       = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         j = IDW'((32'(ptr) + 32'd1 + i) % NUM_REQ);
         if (!any_req && req[j]) begin
            any_req  = 1'b1;
            grant[j] = 1'b1;
            idx      = j;
         end
      end
   end

endmodule

// File: rtl/yl3_display_arbiter.sv
// Shares one YL-3 display driver between NUM_REQ requesters with dwell and periodic refresh.
module yl3_display_arbiter
   import yl3_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned DWELL_CYCLES   = 50_000_000,
   parameter int unsigned REFRESH_CYCLES = 25_000_000,
   parameter int unsigned LOAD_TIMEOUT   = 16,
   localparam int unsigned IDW = yl3_idw(NUM_REQ)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [YL3_MSG_W*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]           grant,
   output logic                         done,
   output logic [IDW-1:0]               owner,
   output logic                         busy,
   output logic                         err_timeout,
   yl3_display_arbiter_if.master        drv
);

   localparam logic [31:0] DwellLast   = (DWELL_CYCLES > 0)   ? 32'(DWELL_CYCLES - 1)   : '0;
   localparam logic [31:0] RefreshLast = (REFRESH_CYCLES > 0) ? 32'(REFRESH_CYCLES - 1) : '0;
   localparam logic [31:0] LoadLast    = (LOAD_TIMEOUT > 0)   ? 32'(LOAD_TIMEOUT - 1)   : '0;

   logic [2:0]           state_q, state_d;
   logic [YL3_MSG_W-1:0] data_q, data_d;
   logic                 load_q, load_d;
   logic [NUM_REQ-1:0]   grant_d;
   logic                 done_d, err_d, busy_d;
   logic [IDW-1:0]       owner_d;
   logic                 msg_valid_q, msg_valid_d;
   logic                 is_refresh_q, is_refresh_d;
   logic                 preempt_q, preempt_d;
   logic [31:0]          refresh_cnt_q, refresh_cnt_d;
   logic [31:0]          dwell_cnt_q, dwell_cnt_d;
   logic [31:0]          load_cnt_q, load_cnt_d;

   logic [NUM_REQ-1:0]   own_mask, arb_req, arb_grant;
   logic [IDW-1:0]       arb_idx;
   logic                 arb_any;

   // An owner preempting its own dwell must not lose the slot to another requester.
   assign own_mask = NUM_REQ'(1) << owner;
   assign arb_req  = preempt_q ? (req & own_mask) : req;

   yl3_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .req     (arb_req),
      .ptr     (owner),
      .grant   (arb_grant),
      .idx     (arb_idx),
      .any_req (arb_any)
   );

   assign drv.drv_data = data_q;
   assign drv.drv_load = load_q;

   always_comb begin
      state_d       = state_q;
      data_d        = data_q;
      load_d        = load_q;
      grant_d       = '0;
      done_d        = 1'b0;
      err_d         = 1'b0;
      owner_d       = owner;
      msg_valid_d   = msg_valid_q;
      is_refresh_d  = is_refresh_q;
      preempt_d     = preempt_q;
      refresh_cnt_d = refresh_cnt_q;
      dwell_cnt_d   = dwell_cnt_q;
      load_cnt_d    = load_cnt_q;
      case (state_q)
         StIdle: begin
            if (|req) begin
               state_d       = StArb;
               preempt_d     = 1'b0;
               refresh_cnt_d = '0;
            end else if (REFRESH_CYCLES != 0 && msg_valid_q && refresh_cnt_q >= RefreshLast) begin
               state_d       = StWaitRdy;
               is_refresh_d  = 1'b1;
               refresh_cnt_d = '0;
            end else begin
               refresh_cnt_d = yl3_sat_inc(refresh_cnt_q);
            end
         end
         StArb: begin
            preempt_d = 1'b0;
            if (arb_any) begin
               data_d       = req_data[YL3_MSG_W*32'(arb_idx) +: YL3_MSG_W];
               owner_d      = arb_idx;
               grant_d      = arb_grant;
               msg_valid_d  = 1'b1;
               is_refresh_d = 1'b0;
               state_d      = StWaitRdy;
            end else begin
               state_d = StIdle;
            end
         end
         StWaitRdy: begin
            if (drv.drv_ready) begin
               load_d     = 1'b1;
               load_cnt_d = '0;
               state_d    = StLoad;
            end
         end
         StLoad: begin
            if (!drv.drv_ready) begin
               load_d  = 1'b0;
               state_d = StBusy;
            end else if (load_cnt_q >= LoadLast) begin
               load_d  = 1'b0;
               err_d   = 1'b1;
               state_d = StIdle;
            end else begin
               load_cnt_d = yl3_sat_inc(load_cnt_q);
            end
         end
         StBusy: begin
            if (drv.drv_ready) begin
               done_d        = 1'b1;
               refresh_cnt_d = '0;
               dwell_cnt_d   = '0;
               state_d       = is_refresh_q ? StIdle : StDwell;
            end
         end
         StDwell: begin
            if (req[owner]) begin
               preempt_d = 1'b1;
               state_d   = StArb;
            end else if (dwell_cnt_q >= DwellLast) begin
               state_d = StIdle;
            end else begin
               dwell_cnt_d = yl3_sat_inc(dwell_cnt_q);
            end
         end
         default: state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         data_q        <= YL3_BLANK_MSG;
         load_q        <= 1'b0;
         grant         <= '0;
         done          <= 1'b0;
         err_timeout   <= 1'b0;
         busy          <= 1'b0;
         owner         <= '0;
         msg_valid_q   <= 1'b0;
         is_refresh_q  <= 1'b0;
         preempt_q     <= 1'b0;
         refresh_cnt_q <= '0;
         dwell_cnt_q   <= '0;
         load_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         data_q        <= data_d;
         load_q        <= load_d;
         grant         <= grant_d;
         done          <= done_d;
         err_timeout   <= err_d;
         busy          <= busy_d;
         owner         <= owner_d;
         msg_valid_q   <= msg_valid_d;
         is_refresh_q  <= is_refresh_d;
         preempt_q     <= preempt_d;
         refresh_cnt_q <= refresh_cnt_d;
         dwell_cnt_q   <= dwell_cnt_d;
         load_cnt_q    <= load_cnt_d;
      end
   end

endmodule
